// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter.
package dmem_pkg;

  localparam int AW_DEF   = 32;
  localparam int DW_DEF   = 32;
  localparam int WORD_LSB = 2;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: one-hot grant among valid requesters allowed by mask.
module dmem_rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic [1:0] eligible;

  assign eligible = valid & mask;

  // On a tie, the requester that did not win last time goes first.
  always_comb begin
    grant = eligible;
    if (&eligible) grant = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port data memory between the load/store unit (0) and a secondary port (1).
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic          req0_lock,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic          req1_lock,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_writedata,
  output logic          mem_memread,
  output logic          mem_memwrite,
  input  logic [DW-1:0] mem_readdata,
  output logic          err_misaligned
);

  state_t        state, state_nxt;
  logic          last_grant;
  logic [1:0]    mask;
  logic [1:0]    grant;
  logic          hs;
  logic          win;
  logic          sel_write;
  logic          sel_lock;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Restrict eligibility to the lock owner while a lock is held.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mask = 2'b11;
    unique case (state)
      LOCK0:   mask = 2'b01;
      LOCK1:   mask = 2'b10;
      default: mask = 2'b11;
    endcase
  end

  dmem_rr_pick u_pick (
    .valid ({req1_valid, req0_valid}),
    .last  (last_grant),
    .mask  (mask),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign hs         = |grant;
  assign win        = grant[1];

  assign sel_write = win ? req1_write : req0_write;
  assign sel_lock  = win ? req1_lock  : req0_lock;
  assign sel_addr  = win ? req1_addr  : req0_addr;
  assign sel_wdata = win ? req1_wdata : req0_wdata;

  // Drive the winner's request onto the memory port; idle port is all zeros.
  always_comb begin
    mem_address   = '0;
    mem_writedata = '0;
    mem_memread   = 1'b0;
    mem_memwrite  = 1'b0;
    if (hs) begin
      mem_address   = sel_addr;
      mem_writedata = sel_wdata;
      mem_memread   = ~sel_write;
      mem_memwrite  = sel_write;
    end
  end

  // Next-state: enter a lock on a locked handshake, leave it on the owner's unlocked handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB:          if (hs && sel_lock)  state_nxt = win ? LOCK1 : LOCK0;
      LOCK0, LOCK1: if (hs && !sel_lock) state_nxt = ARB;
      default:      state_nxt = ARB;
    endcase
  end

  // State register and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state      <= ARB;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (hs) last_grant <= win;
    end
  end

  // Registered load response: data and the matching requester pulse appear the cycle after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rsp0_valid <= hs && !sel_write && !win;
      rsp1_valid <= hs && !sel_write &&  win;
      if (hs && !sel_write) rsp_rdata <= mem_readdata;
    end
  end

  // Sticky misalignment flag; the access itself still goes to the containing word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_misaligned <= 1'b0;
    end else if (hs && (sel_addr[WORD_LSB-1:0] != '0)) begin
      err_misaligned <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed scenarios plus randomized two-requester traffic.
module tb_dmem_port_arbiter;

  typedef struct packed {
    logic        v;
    logic        w;
    logic        l;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          stamp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_write, req0_lock, req0_ready;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_write, req1_lock, req1_ready;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_memread, mem_memwrite;
  logic        err_misaligned;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural memory seen by the DUT.
  logic [31:0] dut_mem [128];
  // Reference view of memory contents, updated in handshake order.
  logic [31:0] ref_mem [128];

  // Reference arbitration rules: lock owner (-1 none) and who wins the next tie.
  int owner;
  int favored;
  bit m_err;

  exp_t exp_q[$];

  dmem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_readdata(mem_readdata), .err_misaligned(err_misaligned)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_readdata = dut_mem[mem_address[8:2]];

  always @(posedge clk) begin
    if (mem_memwrite) dut_mem[mem_address[8:2]] <= mem_writedata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(input bit v, input bit w, input bit l,
                              input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.v = v; r.w = w; r.l = l; r.a = a; r.d = d;
    return r;
  endfunction

  function automatic req_t rand_req(input int lock_pct);
    req_t r;
    r.v = 1'b1;
    r.w = ($urandom_range(0, 99) < 40);
    r.l = ($urandom_range(0, 99) < lock_pct);
    r.a = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
    if ($urandom_range(0, 19) == 0) r.a[1:0] = 2'($urandom_range(1, 3));
    r.d = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    owner   = -1;
    favored = 0;
    m_err   = 1'b0;
    exp_q.delete();
  endtask

  // One bus cycle: drive both requesters, predict the grant, check the port, update the reference.
  task automatic do_cycle(input req_t r0, input req_t r1, output bit hs0, output bit hs1);
    bit   e0, e1;
    int   win;
    req_t r;
    exp_t e;
    req0_valid = r0.v; req0_write = r0.w; req0_lock = r0.l; req0_addr = r0.a; req0_wdata = r0.d;
    req1_valid = r1.v; req1_write = r1.w; req1_lock = r1.l; req1_addr = r1.a; req1_wdata = r1.d;
    @(negedge clk);
    e0  = r0.v && (owner < 0 || owner == 0);
    e1  = r1.v && (owner < 0 || owner == 1);
    win = -1;
    if (e0 && e1)  win = favored;
    else if (e0)   win = 0;
    else if (e1)   win = 1;
    check("req0_ready", req0_ready, 32'(win == 0));
    check("req1_ready", req1_ready, 32'(win == 1));
    check("err_misaligned", err_misaligned, 32'(m_err));
    if (win >= 0) begin
      r = (win == 0) ? r0 : r1;
      check("mem_address", mem_address, r.a);
      check("mem_memwrite", mem_memwrite, 32'(r.w));
      check("mem_memread", mem_memread, 32'(!r.w));
      if (r.w) begin
        check("mem_writedata", mem_writedata, r.d);
        ref_mem[r.a[8:2]] = r.d;
      end else begin
        e.id = win; e.data = ref_mem[r.a[8:2]]; e.stamp = cyc;
        exp_q.push_back(e);
      end
      if (r.a[1:0] != 2'b00) m_err = 1'b1;
      favored = 1 - win;
      owner   = r.l ? win : -1;
    end else begin
      check("mem_idle", {mem_memread, mem_memwrite}, 32'd0);
    end
    hs0 = req0_ready;
    hs1 = req1_ready;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every rsp pulse must match the oldest expected load, one cycle after its handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (rsp0_valid || rsp1_valid) begin
        check("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 32'd0);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {rsp1_valid, rsp0_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 32'(rsp1_valid), 32'(e.id));
          check("rsp_rdata", rsp_rdata, e.data);
          check("rsp_latency", cyc, e.stamp + 1);
        end
      end else if (exp_q.size() > 0 && exp_q[0].stamp + 1 == cyc) begin
        e = exp_q.pop_front();
        check("rsp_missing", {rsp1_valid, rsp0_valid}, (e.id == 0) ? 32'd1 : 32'd2);
      end
    end
  end

  initial begin : stim
    req_t idle;
    req_t pend [2];
    bit   held [2];
    bit   hs0, hs1;
    bit   drain;

    idle = mk(0, 0, 0, 32'd0, 32'd0);
    for (int i = 0; i < 128; i++) begin
      dut_mem[i] = 32'(i);
      ref_mem[i] = 32'(i);
    end
    model_reset();
    rst_n = 1'b0;
    {req0_valid, req0_write, req0_lock, req0_addr, req0_wdata} = '0;
    {req1_valid, req1_write, req1_lock, req1_addr, req1_wdata} = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state with no requests pending.
    check("rst_req0_ready", req0_ready, 32'd0);
    check("rst_req1_ready", req1_ready, 32'd0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_err", err_misaligned, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_ctl", {mem_memread, mem_memwrite}, 32'd0);

    // Contention: both load continuously, grants alternate starting with requester 0.
    for (int k = 0; k < 4; k++) begin
      do_cycle(mk(1, 0, 0, 32'h0, 32'd0), mk(1, 0, 0, 32'h4, 32'd0), hs0, hs1);
      check("contend_grant", {hs1, hs0}, (k % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Single load of word 4.
    do_cycle(mk(1, 0, 0, 32'h10, 32'd0), idle, hs0, hs1);
    check("single_rsp0_valid", rsp0_valid, 32'd1);
    check("single_rsp_rdata", rsp_rdata, 32'd4);

    // Store then load of the same word on the next cycle.
    do_cycle(idle, mk(1, 1, 0, 32'h20, 32'hDEADBEEF), hs0, hs1);
    do_cycle(idle, mk(1, 0, 0, 32'h20, 32'd0), hs0, hs1);
    check("st_ld_rsp1_valid", rsp1_valid, 32'd1);
    check("st_ld_rsp_rdata", rsp_rdata, 32'hDEADBEEF);

    // Lock: requester 0 holds the port across an idle cycle until its unlocked store.
    do_cycle(mk(1, 0, 1, 32'h8, 32'd0), mk(1, 0, 0, 32'h30, 32'd0), hs0, hs1);
    check("lock_take", {hs1, hs0}, 32'd1);
    check("lock_rsp_rdata", rsp_rdata, 32'd2);
    do_cycle(idle, mk(1, 0, 0, 32'h30, 32'd0), hs0, hs1);
    check("lock_idle_block", {hs1, hs0}, 32'd0);
    do_cycle(mk(1, 1, 0, 32'h8, 32'h55), mk(1, 0, 0, 32'h30, 32'd0), hs0, hs1);
    check("lock_release", {hs1, hs0}, 32'd1);
    do_cycle(idle, mk(1, 0, 0, 32'h30, 32'd0), hs0, hs1);
    check("lock_after_grant", {hs1, hs0}, 32'd2);

    // Misaligned load reads the containing word and sets the sticky flag.
    do_cycle(mk(1, 0, 0, 32'h13, 32'd0), idle, hs0, hs1);
    check("misalign_rdata", rsp_rdata, 32'd4);
    check("misalign_err", err_misaligned, 32'd1);
    do_cycle(idle, idle, hs0, hs1);
    do_cycle(mk(1, 0, 0, 32'h14, 32'd0), idle, hs0, hs1);
    check("misalign_sticky", err_misaligned, 32'd1);

    // Randomized traffic, then a drain phase that releases any held lock.
    pend[0] = idle; pend[1] = idle;
    held[0] = 1'b0; held[1] = 1'b0;
    for (int c = 0; c < 1700; c++) begin
      drain = (c >= 1500);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i].v) begin
          if (!drain && $urandom_range(0, 99) < (held[i] ? 70 : 50))
            pend[i] = rand_req(held[i] ? 30 : 15);
          else if (drain && held[i])
            pend[i] = rand_req(0);
        end
      end
      do_cycle(pend[0], pend[1], hs0, hs1);
      if (hs0) begin held[0] = pend[0].l; pend[0] = idle; end
      if (hs1) begin held[1] = pend[1].l; pend[1] = idle; end
      if (drain && !pend[0].v && !pend[1].v && !held[0] && !held[1]) break;
    end
    check("drain_done", {held[1], held[0], pend[1].v, pend[0].v}, 32'd0);
    do_cycle(idle, idle, hs0, hs1);
    do_cycle(idle, idle, hs0, hs1);

    // Reset while locked with a load response in flight.
    do_cycle(mk(1, 0, 1, 32'h8, 32'd0), idle, hs0, hs1);
    check("pre_reset_rsp0", rsp0_valid, 32'd1);
    #1 rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("mid_reset_rsp_valid", {rsp1_valid, rsp0_valid}, 32'd0);
    check("mid_reset_rsp_rdata", rsp_rdata, 32'd0);
    check("mid_reset_err", err_misaligned, 32'd0);
    check("mid_reset_mem_ctl", {mem_memread, mem_memwrite}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_cycle(mk(1, 0, 0, 32'h4, 32'd0), mk(1, 0, 0, 32'hC, 32'd0), hs0, hs1);
    check("post_reset_tie", {hs1, hs0}, 32'd1);
    do_cycle(idle, mk(1, 0, 0, 32'hC, 32'd0), hs0, hs1);
    do_cycle(idle, idle, hs0, hs1);
    do_cycle(idle, idle, hs0, hs1);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
